mux_logic_unit: RTL and testbench



---
 rtl/mlu_pkg.sv | 38 +++
 rtl/mlu_bit_mux.sv | 12 +
 rtl/mux_logic_unit.sv | 93 +++++++++
 tb/tb_mux_logic_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mlu_pkg.sv
// Shared opcode set and per-bit mux-input selection for the mux-based logic unit.
package mlu_pkg;

  localparam int OPW = 3;

  typedef enum logic [OPW-1:0] {
    OP_NOT  = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_XOR  = 3'd3,
    OP_XNOR = 3'd4,
    OP_NAND = 3'd5,
    OP_NOR  = 3'd6,
    OP_PASS = 3'd7
  } mlu_op_e;

  typedef struct packed {
    logic    acc;
    logic    clr;
    mlu_op_e op;
  } mlu_ctl_t;

  // Returns {I1, I0} for one bit; operand A drives the mux select outside.
  function automatic logic [1:0] mlu_mux_inputs(mlu_op_e op, logic b);
    mlu_mux_inputs = 2'b00;
    case (op)
      OP_NOT:  mlu_mux_inputs = {1'b0, 1'b1};
      OP_AND:  mlu_mux_inputs = {b,    1'b0};
      OP_OR:   mlu_mux_inputs = {1'b1, b};
      OP_XOR:  mlu_mux_inputs = {~b,   b};
      OP_XNOR: mlu_mux_inputs = {b,    ~b};
      OP_NAND: mlu_mux_inputs = {~b,   1'b1};
      OP_NOR:  mlu_mux_inputs = {1'b0, ~b};
      OP_PASS: mlu_mux_inputs = {1'b1, 1'b0};
    endcase
  endfunction

endpackage

// File: rtl/mlu_bit_mux.sv
// Single-bit 2:1 mux, the primitive every logic-unit result bit is built from.
// Purely combinational; no latency, no flow control.
module mlu_bit_mux (
  input  logic i0,
  input  logic i1,
  input  logic s,
  output logic y
);

  assign y = s ? i1 : i0;

endmodule

// File: rtl/mux_logic_unit.sv
// Two-stage valid/ready mux-based logic unit with accumulator; 2-cycle latency, 1/cycle, stalls upstream when both stages full.
// Optional MLU_PARITY_EN adds out_par, the registered XOR-reduce of out_y.
module mux_logic_unit
  import mlu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OPW-1:0]   in_op,
  input  logic             in_acc,
  input  logic             in_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [WIDTH-1:0] acc_q
`ifdef MLU_PARITY_EN
  ,
  output logic             out_par
`endif
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  mlu_ctl_t         s1_ctl;
  logic             s2_adv;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] y_nxt;

  assign s2_adv   = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_adv;

  // Clear takes priority over the accumulator value when both are requested.
  assign b_eff = s1_ctl.acc ? (s1_ctl.clr ? '0 : acc_q) : s1_b;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [1:0] mux_in;
    assign mux_in = mlu_mux_inputs(s1_ctl.op, b_eff[i]);
    mlu_bit_mux u_mux (
      .i0 (mux_in[0]),
      .i1 (mux_in[1]),
      .s  (s1_a[i]),
      .y  (y_nxt[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_ctl    <= '{acc: 1'b0, clr: 1'b0, op: OP_NOT};
      out_valid <= 1'b0;
      out_y     <= '0;
      acc_q     <= '0;
    end else begin
      if (in_valid && in_ready) begin
        s1_valid <= 1'b1;
        s1_a     <= in_a;
        s1_b     <= in_b;
        s1_ctl   <= '{acc: in_acc, clr: in_clr, op: mlu_op_e'(in_op)};
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end

      if (s2_adv) begin
        out_valid <= 1'b1;
        out_y     <= y_nxt;
        if (s1_ctl.acc || s1_ctl.clr) begin
          acc_q <= y_nxt;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MLU_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_par <= 1'b0;
    end else if (s2_adv) begin
      out_par <= ^y_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_mux_logic_unit.sv
// Directed bench for mux_logic_unit: opcode table, streaming, backpressure, accumulate, reset.
module tb_mux_logic_unit;
  import mlu_pkg::*;

  localparam int W  = 8;
  localparam int NV = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [2:0]   in_op = '0;
  logic         in_acc = 1'b0;
  logic         in_clr = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_y;
  logic [W-1:0] acc_q;
`ifdef MLU_PARITY_EN
  logic         out_par;
`endif

  mux_logic_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_acc    (in_acc),
    .in_clr    (in_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .acc_q     (acc_q)
`ifdef MLU_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
  } vec_t;

  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;

  logic [W-1:0] src_a [32];
  logic [W-1:0] rcv_y [32];
  int n_acc, n_rcv, ready_low, unstable, first_cyc, last_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                       input logic acc, input logic clr);
    in_valid = 1'b1;
    in_a = a; in_b = b; in_op = op; in_acc = acc; in_clr = clr;
  endtask

  // Streams n items (XOR with 0x5A) through a valid/ready producer and consumer;
  // the consumer refuses for the first 'stall' cycles.
  task automatic stream(input int n, input int stall, input int budget);
    logic [W-1:0] hold_y;
    logic         have_hold;
    logic         fire_in, fire_out;
    n_acc = 0; n_rcv = 0; ready_low = 0; unstable = 0;
    first_cyc = -1; last_cyc = -1; have_hold = 1'b0; hold_y = '0;
    for (int cyc = 0; cyc < budget && n_rcv < n; cyc++) begin
      out_ready = (cyc >= stall);
      in_valid  = (n_acc < n);
      in_a = src_a[n_acc[4:0]]; in_b = 8'h5A; in_op = OP_XOR; in_acc = 1'b0; in_clr = 1'b0;
      #1;
      if (stall > 0 && cyc == stall - 1) begin
        check("bp_accepted_cnt", n_acc, 2);
        check("bp_in_ready_low", in_ready, 0);
      end
      if (in_valid && !in_ready) ready_low++;
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (out_valid && !out_ready) begin
        if (have_hold && out_y !== hold_y) unstable++;
        hold_y = out_y;
        have_hold = 1'b1;
      end
      if (fire_out) begin
        rcv_y[n_rcv[4:0]] = out_y;
        n_rcv++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      @(posedge clk);
      if (fire_in) n_acc++;
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_rcv_count", n_rcv, n);
    for (int i = 0; i < n; i++) check("stream_order", rcv_y[i], src_a[i] ^ 8'h5A);
    check("stream_no_dup", out_valid, 0);
    check("stream_consecutive", last_cyc - first_cyc, n - 1);
  endtask

  initial begin
    vecs[0] = '{OP_NOT,  8'hCA, 8'h5C, 8'h35};
    vecs[1] = '{OP_AND,  8'hCA, 8'h5C, 8'h48};
    vecs[2] = '{OP_OR,   8'hCA, 8'h5C, 8'hDE};
    vecs[3] = '{OP_XOR,  8'hCA, 8'h5C, 8'h96};
    vecs[4] = '{OP_XNOR, 8'hCA, 8'h5C, 8'h69};
    vecs[5] = '{OP_NAND, 8'hCA, 8'h5C, 8'hB7};
    vecs[6] = '{OP_NOR,  8'hCA, 8'h5C, 8'h21};
    vecs[7] = '{OP_PASS, 8'hCA, 8'h5C, 8'hCA};
    vecs[8] = '{OP_AND,  8'h00, 8'hFF, 8'h00};
    vecs[9] = '{OP_XOR,  8'hFF, 8'h00, 8'hFF};

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_y", out_y, 0);
    check("rst_acc_q", acc_q, 0);
    step();
    rst_n = 1'b1;
    step();
    check("rst_in_ready", in_ready, 1);

    // Opcode table, single transactions, 2-cycle latency
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].op, 1'b0, 1'b0);
      step();
      in_valid = 1'b0;
      check("op_lat1_valid", out_valid, 0);
      step();
      check("op_lat2_valid", out_valid, 1);
      check($sformatf("op%0d_y", vecs[i].op), out_y, vecs[i].y);
    end
    check("op_acc_untouched", acc_q, 0);
    step();

    // Throughput: 16 back-to-back
    for (int i = 0; i < 16; i++) src_a[i] = W'(i * 37 + 1);
    stream(16, 0, 100);
    check("tp_in_ready_never_low", ready_low, 0);
    step();

    // Backpressure: 5 stalled cycles, 4 items
    for (int i = 0; i < 4; i++) src_a[i] = W'(8'hA0 + i);
    stream(4, 5, 100);
    check("bp_out_y_stable", unstable, 0);
    step();

    // Accumulate chain, back to back
    drive(8'h0F, 8'hAA, OP_OR, 1'b1, 1'b1);
    step();
    drive(8'hF0, 8'hAA, OP_OR, 1'b1, 1'b0);
    step();
    check("acc1_y", out_y, 8'h0F);
    check("acc1_q", acc_q, 8'h0F);
    drive(8'hFF, 8'hAA, OP_XOR, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    check("acc2_y", out_y, 8'hFF);
    check("acc2_q", acc_q, 8'hFF);
    step();
    check("acc3_y", out_y, 8'h00);
    check("acc3_q", acc_q, 8'h00);

    // Clear without accumulate loads the B-based result
    drive(8'hFF, 8'h3C, OP_AND, 1'b0, 1'b1);
    step();
    drive(8'hF0, 8'h00, OP_AND, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    check("clr_only_y", out_y, 8'h3C);
    check("clr_only_q", acc_q, 8'h3C);
    step();
    check("acc_and_y", out_y, 8'h30);
    check("acc_and_q", acc_q, 8'h30);
    step();

`ifdef MLU_PARITY_EN
    drive(8'h07, 8'h00, OP_PASS, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    check("par_y", out_y, 8'h07);
    check("par_bit", out_par, 1);
    step();
`endif

    // Reset mid-traffic
    drive(8'h55, 8'h00, OP_PASS, 1'b0, 1'b0);
    step();
    drive(8'h66, 8'h00, OP_PASS, 1'b0, 1'b0);
    step();
    check("pre_rst_y", out_y, 8'h55);
    #2 rst_n = 1'b0;
    #1;
    in_valid = 1'b0;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_y", out_y, 0);
    check("mid_rst_acc_q", acc_q, 0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_discard", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
